// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM state encodings for the ALU execute stage.
`timescale 1ns/1ps
package alu_pkg;

  localparam int OPW = 3;

  localparam logic [OPW-1:0] OP_ADD = 3'b000;
  localparam logic [OPW-1:0] OP_SUB = 3'b001;
  localparam logic [OPW-1:0] OP_AND = 3'b010;
  localparam logic [OPW-1:0] OP_OR  = 3'b011;
  localparam logic [OPW-1:0] OP_XOR = 3'b100;
  localparam logic [OPW-1:0] OP_NOT = 3'b101;
  localparam logic [OPW-1:0] OP_MOV = 3'b110;
  localparam logic [OPW-1:0] OP_MUL = 3'b111;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

endpackage

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, N cycles.
// done and prod are combinational and mark the cycle whose closing edge retires the product.
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_MUL  | accumulating one multiplier bit per cycle
`timescale 1ns/1ps
module mul_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] prod
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  logic [0:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;

  // prod already includes the current step so the last cycle's sum is usable at its closing edge
  assign prod = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign busy = (state_q == ST_MUL);
  assign done = (state_q == ST_MUL) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{N{1'b0}}, a};
          mplier_d = b;
        end
      end
      ST_MUL: begin
        acc_d    = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_stage.sv
// Registered ALU execute stage with single-cycle ops and an iterative multiply.
// Build option: define ALU_SAT_EN to saturate ADD/SUB on signed overflow.
`timescale 1ns/1ps
module alu_stage
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [OPW-1:0] op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [N-1:0]   y,
  output logic           z_flag,
  output logic           n_flag,
  output logic           o_flag,
  output logic           busy,
  output logic           done
);

  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0]   y_q, y_d;
  logic           z_q, z_d, n_q, n_d, o_q, o_d;
  logic           done_q, done_d;
  logic           accept, mul_start, mul_busy, mul_done;
  logic [2*N-1:0] mul_prod;
  logic [N-1:0]   sum, diff, res;
  logic           res_ovf;

  assign accept    = en && !mul_busy;
  assign mul_start = accept && (op == OP_MUL);

  mul_seq #(.N(N)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (mul_busy),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        res     = sum;
        res_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      OP_SUB: begin
        res     = diff;
        res_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_MOV: res = a;
      default: res = '0;
    endcase
`ifdef ALU_SAT_EN
    // overflow direction follows operand A's sign for both ADD and SUB
    if (res_ovf) res = a[N-1] ? SAT_MIN : SAT_MAX;
`endif
  end

  always_comb begin
    y_d    = y_q;
    o_d    = o_q;
    done_d = 1'b0;
    if (mul_done) begin
      y_d    = mul_prod[N-1:0];
      o_d    = |mul_prod[2*N-1:N];
      done_d = 1'b1;
    end else if (accept && (op != OP_MUL)) begin
      y_d    = res;
      o_d    = res_ovf;
      done_d = 1'b1;
    end
    z_d = (y_d == '0);
    n_d = y_d[N-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q    <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      o_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      z_q    <= z_d;
      n_q    <= n_d;
      o_q    <= o_d;
      done_q <= done_d;
    end
  end

  assign y      = y_q;
  assign z_flag = z_q;
  assign n_flag = n_q;
  assign o_flag = o_q;
  assign busy   = mul_busy;
  assign done   = done_q;

  // SAT_MAX/SAT_MIN only feed logic in the saturating build
  logic unused_sat;
  assign unused_sat = ^{SAT_MAX, SAT_MIN};

endmodule

// File: tb/tb_alu_stage.sv
// Directed self-checking bench for alu_stage (N=8), expectations follow ALU_SAT_EN.
`timescale 1ns/1ps
module tb_alu_stage;
  import alu_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [OPW-1:0] op;
  logic [7:0]     a, b;
  logic [7:0]     y;
  logic           z_flag, n_flag, o_flag, busy, done;

  int tests = 0;
  int fails = 0;

  alu_stage #(.N(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .op     (op),
    .a      (a),
    .b      (b),
    .y      (y),
    .z_flag (z_flag),
    .n_flag (n_flag),
    .o_flag (o_flag),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [OPW-1:0] o, input logic [7:0] va, input logic [7:0] vb);
    @(negedge clk);
    en = e; op = o; a = va; b = vb;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  cyc;
    logic seen_done;
    rst = 1'b1; en = 1'b0; op = OP_ADD; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", y, 8'h00);
    chk("rst_flags", {z_flag, n_flag, o_flag}, 3'b000);
    chk("rst_busy_done", {busy, done}, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // signed overflow on ADD
    step(1, OP_ADD, 8'h7F, 8'h01);
`ifdef ALU_SAT_EN
    chk("add_ovf_y", y, 8'h7F);
    chk("add_ovf_zno", {z_flag, n_flag, o_flag}, 3'b001);
`else
    chk("add_ovf_y", y, 8'h80);
    chk("add_ovf_zno", {z_flag, n_flag, o_flag}, 3'b011);
`endif
    chk("add_done", done, 1'b1);
    step(0, OP_ADD, 8'h00, 8'h00);
    chk("add_done_pulse", done, 1'b0);
`ifdef ALU_SAT_EN
    chk("add_hold_y", y, 8'h7F);
`else
    chk("add_hold_y", y, 8'h80);
`endif

    // back-to-back SUB then XOR
    step(1, OP_SUB, 8'h05, 8'h05);
    chk("sub_zero_y", y, 8'h00);
    chk("sub_zero_zno", {z_flag, n_flag, o_flag}, 3'b100);
    chk("sub_done", done, 1'b1);
    step(1, OP_XOR, 8'hF0, 8'hFF);
    chk("xor_y", y, 8'h0F);
    chk("xor_b2b_done", done, 1'b1);
    step(1, OP_SUB, 8'h80, 8'h01);
`ifdef ALU_SAT_EN
    chk("sub_ovf_y", y, 8'h80);
    chk("sub_ovf_zno", {z_flag, n_flag, o_flag}, 3'b011);
`else
    chk("sub_ovf_y", y, 8'h7F);
    chk("sub_ovf_zno", {z_flag, n_flag, o_flag}, 3'b001);
`endif
    step(1, OP_NOT, 8'h0F, 8'h00);
    chk("not_y", y, 8'hF0);
    chk("not_zno", {z_flag, n_flag, o_flag}, 3'b010);
    step(1, OP_AND, 8'hF0, 8'h3C);
    chk("and_y", y, 8'h30);
    step(1, OP_OR, 8'h81, 8'h06);
    chk("or_y", y, 8'h87);
    step(1, OP_MOV, 8'h0F, 8'hAA);
    chk("mov_y", y, 8'h0F);

    // MUL 12*10 with an ADD request issued while busy
    step(1, OP_MUL, 8'd12, 8'd10);
    chk("mul_accept_busy", busy, 1'b1);
    chk("mul_accept_done", done, 1'b0);
    for (int i = 1; i < 8; i++) begin
      step((i < 7), OP_ADD, 8'h11, 8'h22);
      chk($sformatf("mul_busy_c%0d", i), {busy, done}, 2'b10);
      chk($sformatf("mul_hold_y_c%0d", i), y, 8'h0F);
    end
    step(0, OP_ADD, 8'h00, 8'h00);
    chk("mul_end_busy_done", {busy, done}, 2'b01);
    chk("mul_y", y, 8'h78);
    chk("mul_zno", {z_flag, n_flag, o_flag}, 3'b000);
    step(0, OP_ADD, 8'h00, 8'h00);
    chk("mul_done_pulse", done, 1'b0);
    chk("mul_ignored_add", y, 8'h78);

    // MUL 16*16: overflow into upper byte, latency measured with a bound
    step(1, OP_MUL, 8'd16, 8'd16);
    @(negedge clk);
    en = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mul16_latency", cyc, 32'd9);
    chk("mul16_y", y, 8'h00);
    chk("mul16_zno", {z_flag, n_flag, o_flag}, 3'b101);

    // MUL 255*255 = 0xFE01
    step(1, OP_MUL, 8'hFF, 8'hFF);
    repeat (7) step(0, OP_ADD, 8'h00, 8'h00);
    step(0, OP_ADD, 8'h00, 8'h00);
    chk("mul255_y", y, 8'h01);
    chk("mul255_o_done", {o_flag, done}, 2'b11);

    // reset during the 4th MUL cycle
    step(1, OP_MOV, 8'h55, 8'h00);
    chk("pre_rst_y", y, 8'h55);
    step(1, OP_MUL, 8'd3, 8'd3);
    repeat (3) step(0, OP_ADD, 8'h00, 8'h00);
    chk("pre_rst_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_y", y, 8'h00);
    chk("midrst_busy_done", {busy, done}, 2'b00);
    chk("midrst_flags", {z_flag, n_flag, o_flag}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, OP_ADD, 8'h00, 8'h00);
      seen_done = seen_done | done | busy;
    end
    chk("postrst_no_done", seen_done, 1'b0);
    chk("postrst_y", y, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
